// File: rtl/dram_pipe_if.sv
// Request/response bus of dram_pipe: one request channel (read or byte-masked write)
// and one read-response channel, each with a valid/ready handshake.
interface dram_pipe_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Handshake rule on both channels: a beat transfers on a rising clk edge where
  // valid and ready are both high; ready never depends on valid in the same cycle.
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dram_pipe.sv
// Single-port word memory with byte-masked writes and an RD_LAT-stage stallable read pipe.
// Optional performance counters are built only when DRAM_PIPE_PERF_EN is defined.
module dram_pipe #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 0
) (
  input  logic        clk,
  input  logic        rst,
  dram_pipe_if.slave  bus,
  output logic        busy,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [31:0] stall_cnt,
  output logic        dbg_state
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] pipe_v;
  logic [DATA_W-1:0] pipe_d [RD_LAT];

  logic stall;
  logic req_acc;
  logic rd_acc;
  logic wr_acc;
  logic clr_wr;

  // The last pipe stage is the response register; a held response freezes every stage.
  assign stall   = pipe_v[RD_LAT-1] && !bus.rsp_ready;
  assign req_acc = bus.req_valid && bus.req_ready;
  assign rd_acc  = req_acc && (bus.req_we == '0);
  assign wr_acc  = req_acc && (bus.req_we != '0);
  assign clr_wr  = (state == ST_CLEAR) && !rst;

  assign bus.rsp_valid = pipe_v[RD_LAT-1];
  assign bus.rsp_rdata = pipe_d[RD_LAT-1];
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_idx == '1) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Requests are refused while reset is asserted even when the state register reads RUN.
  always_comb begin
    busy          = (state == ST_CLEAR);
    bus.req_ready = (state == ST_RUN) && !stall && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // Memory has no reset; contents survive rst unless the CLEAR sweep runs.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.req_we[b]) mem[bus.req_addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_d[k] <= '0;
    end else if (!stall) begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) pipe_d[0] <= mem[bus.req_addr];
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

`ifdef DRAM_PIPE_PERF_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_acc) rd_cnt_q    <= rd_cnt_q + 32'd1;
      if (wr_acc) wr_cnt_q    <= wr_cnt_q + 32'd1;
      if (stall)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign rd_cnt    = '0;
  assign wr_cnt    = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_dram_pipe.sv
// Directed bench for dram_pipe: four instances cover RD_LAT 1/3/2 and the
// CLEAR_ON_RST sweep; expected values are hand-computed constants.
module tb_dram_pipe;
`ifdef DRAM_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_a, rst_b, rst_c, rst_d;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cnt;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dram_pipe_if #(.ADDR_W(16), .DATA_W(32)) a_if ();
  dram_pipe_if #(.ADDR_W(8),  .DATA_W(32)) b_if ();
  dram_pipe_if #(.ADDR_W(4),  .DATA_W(32)) c_if ();
  dram_pipe_if #(.ADDR_W(4),  .DATA_W(32)) d_if ();

  logic        a_busy, b_busy, c_busy, d_busy;
  logic        a_st, b_st, c_st, d_st;
  logic [31:0] a_rd, a_wr, a_stl, b_rd, b_wr, b_stl;
  logic [31:0] c_rd, c_wr, c_stl, d_rd, d_wr, d_stl;

  dram_pipe #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .CLEAR_ON_RST(0)) u_a (
    .clk(clk), .rst(rst_a), .bus(a_if.slave), .busy(a_busy),
    .rd_cnt(a_rd), .wr_cnt(a_wr), .stall_cnt(a_stl), .dbg_state(a_st));
  dram_pipe #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3), .CLEAR_ON_RST(0)) u_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave), .busy(b_busy),
    .rd_cnt(b_rd), .wr_cnt(b_wr), .stall_cnt(b_stl), .dbg_state(b_st));
  dram_pipe #(.ADDR_W(4), .DATA_W(32), .RD_LAT(2), .CLEAR_ON_RST(0)) u_c (
    .clk(clk), .rst(rst_c), .bus(c_if.slave), .busy(c_busy),
    .rd_cnt(c_rd), .wr_cnt(c_wr), .stall_cnt(c_stl), .dbg_state(c_st));
  dram_pipe #(.ADDR_W(4), .DATA_W(32), .RD_LAT(1), .CLEAR_ON_RST(1)) u_d (
    .clk(clk), .rst(rst_d), .bus(d_if.slave), .busy(d_busy),
    .rd_cnt(d_rd), .wr_cnt(d_wr), .stall_cnt(d_stl), .dbg_state(d_st));

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks for instance A (RD_LAT=1): each returns on the next falling edge
  task automatic a_write(input logic [15:0] addr, input logic [3:0] we, input logic [31:0] data);
    a_if.req_valid = 1'b1;
    a_if.req_addr  = addr;
    a_if.req_we    = we;
    a_if.req_wdata = data;
    @(negedge clk);
  endtask

  task automatic a_read(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    a_if.req_valid = 1'b1;
    a_if.req_addr  = addr;
    a_if.req_we    = 4'h0;
    #1;
    check({tag, "_ready"}, {31'd0, a_if.req_ready}, 32'd1);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, a_if.rsp_valid}, 32'd1);
    check(tag, a_if.rsp_rdata, exp);
  endtask

  task automatic a_idle();
    a_if.req_valid = 1'b0;
    a_if.req_we    = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    a_if.req_valid = 0; a_if.req_addr = '0; a_if.req_we = '0; a_if.req_wdata = '0; a_if.rsp_ready = 1;
    b_if.req_valid = 0; b_if.req_addr = '0; b_if.req_we = '0; b_if.req_wdata = '0; b_if.rsp_ready = 1;
    c_if.req_valid = 0; c_if.req_addr = '0; c_if.req_we = '0; c_if.req_wdata = '0; c_if.rsp_ready = 1;
    d_if.req_valid = 0; d_if.req_addr = '0; d_if.req_we = '0; d_if.req_wdata = '0; d_if.rsp_ready = 1;
    repeat (2) @(negedge clk);

    // reset state
    check("a_rst_ready", {31'd0, a_if.req_ready}, 32'd0);
    check("a_rst_rsp_valid", {31'd0, a_if.rsp_valid}, 32'd0);
    check("a_rst_rdata", a_if.rsp_rdata, 32'd0);
    check("a_rst_busy", {31'd0, a_busy}, 32'd0);
    check("a_rst_rd_cnt", a_rd, 32'd0);
    check("d_rst_busy", {31'd0, d_busy}, 32'd1);
    check("d_rst_ready", {31'd0, d_if.req_ready}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    check("a_run_ready", {31'd0, a_if.req_ready}, 32'd1);

    // A: full write then read-after-write, RD_LAT=1
    a_write(16'h0010, 4'hF, 32'hDEADBEEF);
    a_read(16'h0010, 32'hDEADBEEF, "a_rd_after_wr");
    a_idle();
    check("a_rsp_drained", {31'd0, a_if.rsp_valid}, 32'd0);

    // A: partial write merge, then back-to-back reads
    a_write(16'h0020, 4'hF, 32'h11223344);
    a_write(16'h0020, 4'b0101, 32'hAABBCCDD);
    a_read(16'h0020, 32'h11BB33DD, "a_merge");
    a_read(16'h0010, 32'hDEADBEEF, "a_b2b0");
    a_read(16'h0020, 32'h11BB33DD, "a_b2b1");
    a_read(16'h0010, 32'hDEADBEEF, "a_b2b2");
    a_idle();
    check("a_rd_cnt", a_rd, PERF ? 32'd5 : 32'd0);
    check("a_wr_cnt", a_wr, PERF ? 32'd3 : 32'd0);
    check("a_stall_cnt", a_stl, 32'd0);

    // A: reset clears counters but keeps memory
    rst_a = 1'b1;
    #1;
    check("a_rst2_ready", {31'd0, a_if.req_ready}, 32'd0);
    @(negedge clk);
    check("a_rst2_rd_cnt", a_rd, 32'd0);
    check("a_rst2_wr_cnt", a_wr, 32'd0);
    rst_a = 1'b0;
    a_read(16'h0010, 32'hDEADBEEF, "a_keep_after_rst");
    a_idle();

    // B: RD_LAT=3, three consecutive reads, 2-cycle consumer stall
    for (int i = 1; i <= 3; i++) begin
      b_if.req_valid = 1'b1; b_if.req_addr = 8'(i); b_if.req_we = 4'hF; b_if.req_wdata = 32'(i);
      @(negedge clk);
    end
    for (int i = 1; i <= 3; i++) begin
      b_if.req_valid = 1'b1; b_if.req_addr = 8'(i); b_if.req_we = 4'h0;
      #1;
      check("b_rd_ready", {31'd0, b_if.req_ready}, 32'd1);
      check("b_no_early_rsp", {31'd0, b_if.rsp_valid}, 32'd0);
      @(negedge clk);
    end
    b_if.req_valid = 1'b0;
    b_if.rsp_ready = 1'b0;
    #1;
    check("b_rsp1_valid", {31'd0, b_if.rsp_valid}, 32'd1);
    check("b_rsp1_data", b_if.rsp_rdata, 32'd1);
    check("b_stall_ready0", {31'd0, b_if.req_ready}, 32'd0);
    @(negedge clk);
    check("b_hold1_data", b_if.rsp_rdata, 32'd1);
    check("b_stall_ready1", {31'd0, b_if.req_ready}, 32'd0);
    @(negedge clk);
    check("b_hold2_data", b_if.rsp_rdata, 32'd1);
    check("b_stall_ready2", {31'd0, b_if.req_ready}, 32'd0);
    b_if.rsp_ready = 1'b1;
    @(negedge clk);
    check("b_rsp2_valid", {31'd0, b_if.rsp_valid}, 32'd1);
    check("b_rsp2_data", b_if.rsp_rdata, 32'd2);
    check("b_unstall_ready", {31'd0, b_if.req_ready}, 32'd1);
    @(negedge clk);
    check("b_rsp3_data", b_if.rsp_rdata, 32'd3);
    @(negedge clk);
    check("b_rsp_done", {31'd0, b_if.rsp_valid}, 32'd0);
    check("b_stall_cnt", b_stl, PERF ? 32'd2 : 32'd0);
    check("b_rd_cnt", b_rd, PERF ? 32'd3 : 32'd0);
    check("b_wr_cnt", b_wr, PERF ? 32'd3 : 32'd0);

    // C: RD_LAT=2, reset while a read is in flight discards it
    c_if.req_valid = 1'b1; c_if.req_addr = 4'd5; c_if.req_we = 4'hF; c_if.req_wdata = 32'h5A5A0005;
    @(negedge clk);
    c_if.req_we = 4'h0;
    @(negedge clk);
    c_if.req_valid = 1'b0;
    rst_c = 1'b1;
    #1;
    check("c_rst_ready", {31'd0, c_if.req_ready}, 32'd0);
    @(negedge clk);
    rst_c = 1'b0;
    check("c_flushed", {31'd0, c_if.rsp_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("c_no_rsp", {31'd0, c_if.rsp_valid}, 32'd0);
    end
    c_if.req_valid = 1'b1; c_if.req_addr = 4'd5; c_if.req_we = 4'h0;
    @(negedge clk);
    c_if.req_valid = 1'b0;
    check("c_lat2_not_yet", {31'd0, c_if.rsp_valid}, 32'd0);
    @(negedge clk);
    check("c_keep_valid", {31'd0, c_if.rsp_valid}, 32'd1);
    check("c_keep_data", c_if.rsp_rdata, 32'h5A5A0005);
    @(negedge clk);
    check("c_single_rsp", {31'd0, c_if.rsp_valid}, 32'd0);

    // D: CLEAR_ON_RST=1, ADDR_W=4 sweep after reset
    rst_d = 1'b0;
    cnt = 0;
    while (d_busy === 1'b1 && cnt < 40) begin
      check("d_busy_ready", {31'd0, d_if.req_ready}, 32'd0);
      cnt++;
      @(negedge clk);
    end
    check("d_clear_len0", cnt, 32'd16);
    check("d_run_ready", {31'd0, d_if.req_ready}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      d_if.req_valid = 1'b1; d_if.req_addr = 4'(i); d_if.req_we = 4'hF; d_if.req_wdata = 32'hFFFFFFFF;
      @(negedge clk);
    end
    d_if.req_addr = 4'd7; d_if.req_we = 4'h0;
    @(negedge clk);
    d_if.req_valid = 1'b0;
    check("d_preload", d_if.rsp_rdata, 32'hFFFFFFFF);

    // reset, interrupt the sweep after 5 words, then it must restart from word 0
    rst_d = 1'b1;
    @(negedge clk);
    rst_d = 1'b0;
    repeat (5) @(negedge clk);
    rst_d = 1'b1;
    @(negedge clk);
    rst_d = 1'b0;
    cnt = 0;
    while (d_busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("d_clear_restart_len", cnt, 32'd16);
    for (int i = 0; i < 16; i++) begin
      d_if.req_valid = 1'b1; d_if.req_addr = 4'(i); d_if.req_we = 4'h0;
      @(negedge clk);
      check("d_cleared_valid", {31'd0, d_if.rsp_valid}, 32'd1);
      check("d_cleared_word", d_if.rsp_rdata, 32'd0);
    end
    d_if.req_valid = 1'b0;
    @(negedge clk);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_pipe.md
DRAM_PIPE -- requirements
Module: dram_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, word width; legal values are multiples of 8; BE_W = DATA_W/8.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 SHALL have parameter CLEAR_ON_RST, default 0; when 1, memory is zeroed after every reset.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-009 SHALL have port req_addr  input  ADDR_W  word address.
REQ-010 SHALL have port req_we  input  BE_W  byte write enables; all-zero means read.
REQ-011 SHALL have port req_wdata  input  DATA_W  write data, byte lanes aligned with req_we.
REQ-012 SHALL have port rsp_valid  output  1  read data present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts read data.
REQ-014 SHALL have port rsp_rdata  output  DATA_W  read data.
REQ-015 SHALL have port busy  output  1  high while in state CLEAR.
REQ-016 SHALL have ports rd_cnt, wr_cnt, stall_cnt  output  32 each  performance counters (see REQ-033).

Function
REQ-017 SHALL implement states CLEAR and RUN; after reset -> CLEAR if CLEAR_ON_RST=1, else RUN.
REQ-018 In CLEAR: SHALL write zero to word clr_idx each cycle, clr_idx counting 0..2**ADDR_W-1; after the last word, go to RUN on the next edge; busy=1, req_ready=0.
REQ-019 A request SHALL be accepted on an edge where req_valid && req_ready are both high.
REQ-020 Accepted write (req_we != 0): each byte lane i with req_we[i]=1 updated at that edge; other lanes unchanged; no response generated.
REQ-021 Accepted read (req_we == 0): array sampled at the accept edge; data presented with rsp_valid=1 exactly RD_LAT cycles later if no stall occurs.
REQ-022 Read pipeline: RD_LAT stages, each a valid bit plus data; stage RD_LAT drives rsp_valid/rsp_rdata.
REQ-023 Stall = rsp_valid && !rsp_ready; during stall all stages SHALL hold and req_ready SHALL be 0.
REQ-024 req_ready = (state==RUN) && !stall; it SHALL NOT depend on req_valid.
REQ-025 Partial writes SHALL be merged in-array; the caller never performs read-modify-write.
REQ-026 A read accepted the cycle after a write to the same address SHALL return the written data.
REQ-027 Responses SHALL be returned in acceptance order; none dropped or duplicated except at reset (REQ-030).
REQ-028 Back-to-back reads SHALL sustain one accept per cycle while rsp_ready=1.
REQ-029 Address is modulo depth by construction; no out-of-range case exists.

Reset
REQ-030 rst=1 SHALL clear all pipeline valid bits (in-flight reads discarded), rsp_valid=0, rsp_rdata=0, clr_idx=0, and all counters=0.
REQ-031 Memory contents SHALL be preserved through reset when CLEAR_ON_RST=0.
REQ-032 rst asserted during CLEAR SHALL restart clearing from word 0; req_ready=0 while rst=1.

Configuration
REQ-033 Macro DRAM_PIPE_PERF_EN defined: rd_cnt +1 per accepted read, wr_cnt +1 per accepted write, stall_cnt +1 per stall cycle; all wrap at 2**32.
REQ-034 Macro DRAM_PIPE_PERF_EN undefined: rd_cnt, wr_cnt, stall_cnt tied to 0, no counter registers; all other behaviour identical.

Verification
REQ-035 RD_LAT=1: write 0xDEADBEEF at addr 0x0010 with we=4'hF, then read 0x0010 -> rsp_valid one cycle after accept, rsp_rdata=0xDEADBEEF.
REQ-036 Word at 0x0020 = 0x11223344; write we=4'b0101, wdata=0xAABBCCDD; read -> 0x11BB33DD.
REQ-037 RD_LAT=3: reads of 0x1, 0x2, 0x3 on consecutive cycles (data 1, 2, 3), rsp_ready low for 2 cycles at first response -> req_ready=0 those cycles; responses 1, 2, 3 in order; stall_cnt=2 with PERF_EN.
REQ-038 RD_LAT=2: read accepted, rst pulsed next cycle -> no rsp_valid afterwards; word content unchanged on a later read.
REQ-039 CLEAR_ON_RST=1, ADDR_W=4: preload 0xFFFFFFFF everywhere, rst -> busy=1 for 16 cycles, then every word reads 0.
REQ-040 PERF_EN: 5 reads + 3 writes -> rd_cnt=5, wr_cnt=3; without the macro, all three counters stay 0.
